instr_sequencer: RTL and testbench

//  Sequences the 9-bit-ISA datapath: owns the program counter and run/halt state.

---
 rtl/instr_sequencer.sv | 102 ++++++++++
 tb/tb_instr_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter and run/halt control for the 9-bit-ISA datapath; optional cycle counter under SEQ_CYCLE_CNT_EN
module instr_sequencer #(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             Start_i,
  input  logic [PC_W-1:0]  StartAddr_i,
  input  logic             Jen_i,
  input  logic             BranchTkn_i,
  input  logic [PC_W-1:0]  JumpTarget_i,
  input  logic             RenD_i,
  input  logic             Done_i,
  output logic [PC_W-1:0]  ProgCtr_o,
  output logic             DpEn_o,
  output logic             Busy_o,
  output logic             Ack_o,
  output logic             Overflow_o,
  output logic [CNT_W-1:0] CycleCnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, LOAD_WAIT, HALT} state_t;
  localparam bit HAS_WAIT = MEM_LAT > 0;
  localparam logic [1:0] WLAT = 2'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic ovf_q, ovf_d, start_q, wrap, run_start;
  logic [1:0] wcnt_q, wcnt_d;
  assign pc_inc = pc_q + 1'b1;
  assign wrap = &pc_q;
  // restart from HALT needs a fresh Start edge, so IDLE is level-started but HALT is edge-started
  assign run_start = (state_q == IDLE && Start_i) || (state_q == HALT && Start_i && !start_q);
  // state, program counter and sticky flags
  always_ff @(posedge Clk_i or posedge Reset_i)
    if (Reset_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      wcnt_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      wcnt_q  <= wcnt_d;
      start_q <= Start_i;
    end
  // next state: halt beats branch beats load stall beats sequential fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE, HALT:
        if (run_start) begin
          state_d = RUN;
          pc_d    = StartAddr_i;
          ovf_d   = 1'b0;
        end
      RUN:
        if (Done_i) state_d = HALT;
        else if (Jen_i && BranchTkn_i) pc_d = JumpTarget_i;
        else if (!Jen_i && RenD_i && HAS_WAIT) begin
          state_d = LOAD_WAIT;
          wcnt_d  = WLAT;
        end else begin
          pc_d    = pc_inc;
          ovf_d   = ovf_q | wrap;
          state_d = wrap ? HALT : RUN;
        end
      default:
        if (wcnt_q != 2'd0) wcnt_d = wcnt_q - 2'd1;
        else begin
          pc_d    = pc_inc;
          ovf_d   = ovf_q | wrap;
          state_d = wrap ? HALT : RUN;
        end
    endcase
  end
  // outputs: DpEn follows the current instruction, the rest are Moore
  always_comb begin
    DpEn_o = state_q == RUN ? !Done_i && (Jen_i || !(RenD_i && HAS_WAIT)) :
             state_q == LOAD_WAIT ? wcnt_q == 2'd0 : 1'b0;
    Busy_o = state_q == RUN || state_q == LOAD_WAIT;
    Ack_o  = state_q == HALT;
  end
  assign ProgCtr_o  = pc_q;
  assign Overflow_o = ovf_q;
`ifdef SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  // saturating count of busy cycles, cleared whenever a run begins
  always_ff @(posedge Clk_i or posedge Reset_i)
    if (Reset_i) cnt_q <= '0;
    else if (run_start) cnt_q <= '0;
    else if (Busy_o && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign CycleCnt_o = cnt_q;
`else
  assign CycleCnt_o = '0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer, one wide (MEM_LAT=2) and one narrow (PC_W=4) instance
module tb_instr_sequencer;
  logic clk = 1'b0, rst, st, jen, tkn, rend, done;
  logic [9:0] sa, jt;
  logic [9:0] pc0;
  logic [3:0] pcw;
  logic dp0, b0, a0, o0, dpw, bw, aw, ow;
  logic [15:0] c0, cw;
  typedef struct {int id; int n; logic [29:0] v;} rec_t;
  rec_t q[$];
  rec_t mr;
  logic [29:0] act;
  int checks = 0, passed = 0, nrec = 0;
  logic [15:0] mc = '0;
  logic mpb = 1'b0;
  always #5 clk = ~clk;
  instr_sequencer #(.PC_W(10), .MEM_LAT(2), .CNT_W(16)) dut (
    .Clk_i(clk), .Reset_i(rst), .Start_i(st), .StartAddr_i(sa), .Jen_i(jen), .BranchTkn_i(tkn),
    .JumpTarget_i(jt), .RenD_i(rend), .Done_i(done), .ProgCtr_o(pc0), .DpEn_o(dp0), .Busy_o(b0),
    .Ack_o(a0), .Overflow_o(o0), .CycleCnt_o(c0));
  instr_sequencer #(.PC_W(4), .MEM_LAT(1), .CNT_W(16)) dut_w (
    .Clk_i(clk), .Reset_i(rst), .Start_i(st), .StartAddr_i(sa[3:0]), .Jen_i(jen), .BranchTkn_i(tkn),
    .JumpTarget_i(jt[3:0]), .RenD_i(rend), .Done_i(done), .ProgCtr_o(pcw), .DpEn_o(dpw), .Busy_o(bw),
    .Ack_o(aw), .Overflow_o(ow), .CycleCnt_o(cw));
  // push the expected outputs for the current cycle, then advance one cycle
  task automatic exp(input int id, input logic [9:0] pc, input logic dp, b, a, o);
    rec_t r;
    logic [15:0] ec;
    if (rst) begin
      mc = '0;
      mpb = 1'b0;
    end else begin
      if (b && !mpb) mc = '0;
      else if (mpb) mc = mc + 16'd1;
      mpb = b;
    end
`ifdef SEQ_CYCLE_CNT_EN
    ec = mc;
`else
    ec = '0;
`endif
    nrec++;
    r.id = id;
    r.n = nrec;
    r.v = {pc, dp, b, a, o, ec};
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask
  // monitor: compare selected instance against the head of the scoreboard mid-cycle
  always @(negedge clk)
    if (q.size() != 0) begin
      mr = q.pop_front();
      act = mr.id == 0 ? {pc0, dp0, b0, a0, o0, c0} : {6'd0, pcw, dpw, bw, aw, ow, cw};
      checks++;
      if (act === mr.v) passed++;
      else $display("FAIL chk%0d: got pc=%0d dp/busy/ack/ovf=%b cnt=%0d, expected pc=%0d dp/busy/ack/ovf=%b cnt=%0d",
                    mr.n, act[29:20], act[19:16], act[15:0], mr.v[29:20], mr.v[19:16], mr.v[15:0]);
    end
  initial begin
    {rst, st, jen, tkn, rend, done, sa, jt} = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    exp(0, 0, 0, 0, 0, 0);
    st = 1'b1; sa = 10'd5;
    exp(0, 0, 0, 0, 0, 0);
    exp(0, 5, 1, 1, 0, 0);
    exp(0, 6, 1, 1, 0, 0);
    exp(0, 7, 1, 1, 0, 0);
    jen = 1'b1; tkn = 1'b1; jt = 10'd20;
    exp(0, 8, 1, 1, 0, 0);
    tkn = 1'b0;
    exp(0, 20, 1, 1, 0, 0);
    jen = 1'b0; rend = 1'b1;
    exp(0, 21, 0, 1, 0, 0);
    jen = 1'b1; tkn = 1'b1; jt = 10'd300;
    exp(0, 21, 0, 1, 0, 0);
    jen = 1'b0; tkn = 1'b0; done = 1'b1;
    exp(0, 21, 1, 1, 0, 0);
    rend = 1'b0; done = 1'b0;
    exp(0, 22, 1, 1, 0, 0);
    done = 1'b1; jen = 1'b1; tkn = 1'b1; jt = 10'd40;
    exp(0, 23, 0, 1, 0, 0);
    done = 1'b0; jen = 1'b0; tkn = 1'b0;
    exp(0, 23, 0, 0, 1, 0);
    exp(0, 23, 0, 0, 1, 0);
    st = 1'b0;
    exp(0, 23, 0, 0, 1, 0);
    st = 1'b1; sa = 10'd100;
    exp(0, 23, 0, 0, 1, 0);
    exp(0, 100, 1, 1, 0, 0);
    st = 1'b0;
    exp(0, 101, 1, 1, 0, 0);
    st = 1'b1; sa = 10'd7;
    exp(0, 102, 1, 1, 0, 0);
    st = 1'b0; rend = 1'b1;
    exp(0, 103, 0, 1, 0, 0);
    rst = 1'b1;
    exp(0, 0, 0, 0, 0, 0);
    rst = 1'b0; rend = 1'b0;
    exp(0, 0, 0, 0, 0, 0);
    st = 1'b1; sa = 10'd50;
    exp(0, 0, 0, 0, 0, 0);
    st = 1'b0;
    for (int i = 0; i < 6; i++) exp(0, 10'(50 + i), 1, 1, 0, 0);
    done = 1'b1;
    exp(0, 56, 0, 1, 0, 0);
    done = 1'b0;
    exp(0, 56, 0, 0, 1, 0);
    rst = 1'b1;
    exp(1, 0, 0, 0, 0, 0);
    rst = 1'b0; st = 1'b1; sa = 10'd14;
    exp(1, 0, 0, 0, 0, 0);
    exp(1, 14, 1, 1, 0, 0);
    exp(1, 15, 1, 1, 0, 0);
    exp(1, 0, 0, 0, 1, 1);
    st = 1'b0;
    exp(1, 0, 0, 0, 1, 1);
    st = 1'b1; sa = 10'd2;
    exp(1, 0, 0, 0, 1, 1);
    rend = 1'b1;
    exp(1, 2, 0, 1, 0, 0);
    exp(1, 2, 1, 1, 0, 0);
    rend = 1'b0; jen = 1'b1; tkn = 1'b1; jt = 10'd15;
    exp(1, 3, 1, 1, 0, 0);
    jt = 10'd0;
    exp(1, 15, 1, 1, 0, 0);
    jen = 1'b0; tkn = 1'b0;
    exp(1, 0, 1, 1, 0, 0);
    exp(1, 1, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d unchecked records, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
